// File: rtl/pipe_pkg.sv
// Shared constants and payload types for the fetch/decode/execute pipeline registers.
package pipe_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned CTRL_W     = 12;

    // Control bundle bit positions; bits 4:0 are the architecturally visible effects.
    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMWRITE = 1;
    localparam int unsigned CTRL_MEMTOREG = 2;
    localparam int unsigned CTRL_PCS      = 3;
    localparam int unsigned CTRL_BRANCH   = 4;
    localparam logic [4:0]  CTRL_SIDE_EFFECT = 5'h1F;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE1A0_0000;
    localparam logic [DATA_W-1:0]  RESET_PC  = 32'h0000_0000;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] ra1;
        logic [REG_ADDR_W-1:0] ra2;
        logic [REG_ADDR_W-1:0] wa3;
    } reg_addr_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value; clear wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/fetch_decode_pipe.sv
// PC, IF/ID and ID/EX registers driven by the hazard unit, plus stall/flush event counters.
module fetch_decode_pipe #(
    parameter int unsigned        DATA_W    = pipe_pkg::DATA_W,
    parameter logic [DATA_W-1:0]  RESET_PC  = pipe_pkg::RESET_PC,
    parameter logic [31:0]        NOP_INSTR = pipe_pkg::NOP_INSTR,
    parameter int unsigned        CTRL_W    = pipe_pkg::CTRL_W,
    parameter int unsigned        CNT_W     = 32
) (
    input  logic                                CLK,
    input  logic                                RESETn,
    input  logic                                StallF,
    input  logic                                StallD,
    input  logic                                FlashD,
    input  logic                                FlashE,
    input  logic                                PCSrcE,
    input  logic [DATA_W-1:0]                   BranchTargetE,
    input  logic [31:0]                         InstrF,
    output logic [DATA_W-1:0]                   PCF,
    output logic [31:0]                         InstrD,
    output logic [DATA_W-1:0]                   PCPlus4D,
    output logic                                ValidD,
    input  logic [pipe_pkg::REG_ADDR_W-1:0]     RA1D,
    input  logic [pipe_pkg::REG_ADDR_W-1:0]     RA2D,
    input  logic [pipe_pkg::REG_ADDR_W-1:0]     WA3D,
    input  logic [DATA_W-1:0]                   RD1D,
    input  logic [DATA_W-1:0]                   RD2D,
    input  logic [DATA_W-1:0]                   ExtImmD,
    input  logic [CTRL_W-1:0]                   CtrlD,
    output logic [pipe_pkg::REG_ADDR_W-1:0]     RA1E,
    output logic [pipe_pkg::REG_ADDR_W-1:0]     RA2E,
    output logic [pipe_pkg::REG_ADDR_W-1:0]     WA3E,
    output logic [DATA_W-1:0]                   RD1E,
    output logic [DATA_W-1:0]                   RD2E,
    output logic [DATA_W-1:0]                   ExtImmE,
    output logic [CTRL_W-1:0]                   CtrlE,
    output logic                                ValidE,
    input  logic                                CntClr,
    output logic [CNT_W-1:0]                    StallCnt,
    output logic [CNT_W-1:0]                    FlushCnt
);

    import pipe_pkg::*;

    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

    logic [DATA_W-1:0] pc_q, pc_d, pc_plus4_f;

    logic [31:0]       instr_d_q, instr_d_d;
    logic [DATA_W-1:0] pc_plus4_d_q, pc_plus4_d_d;
    logic              valid_d_q, valid_d_d;

    reg_addr_t         addr_e_q, addr_e_d;
    logic [DATA_W-1:0] rd1_e_q, rd1_e_d;
    logic [DATA_W-1:0] rd2_e_q, rd2_e_d;
    logic [DATA_W-1:0] imm_e_q, imm_e_d;
    logic [CTRL_W-1:0] ctrl_e_q, ctrl_e_d;
    logic              valid_e_q, valid_e_d;

    // Fetch PC: a taken branch redirects even while fetch is stalled.
    always_comb begin
        pc_plus4_f = pc_q + PC_STEP;
        pc_d       = pc_q;
        if (PCSrcE) begin
            pc_d = BranchTargetE;
        end else if (!StallF) begin
            pc_d = pc_plus4_f;
        end
    end

    // IF/ID: flush beats stall so a redirect always kills the wrong-path fetch.
    always_comb begin
        instr_d_d    = instr_d_q;
        pc_plus4_d_d = pc_plus4_d_q;
        valid_d_d    = valid_d_q;
        if (FlashD) begin
            instr_d_d    = NOP_INSTR;
            pc_plus4_d_d = '0;
            valid_d_d    = 1'b0;
        end else if (!StallD) begin
            instr_d_d    = InstrF;
            pc_plus4_d_d = pc_plus4_f;
            valid_d_d    = 1'b1;
        end
    end

    // ID/EX: never holds; a bubble zeroes everything, including the side-effect control bits.
    always_comb begin
        addr_e_d  = '0;
        rd1_e_d   = '0;
        rd2_e_d   = '0;
        imm_e_d   = '0;
        ctrl_e_d  = '0;
        valid_e_d = 1'b0;
        if (!FlashE) begin
            addr_e_d  = '{ra1: RA1D, ra2: RA2D, wa3: WA3D};
            rd1_e_d   = RD1D;
            rd2_e_d   = RD2D;
            imm_e_d   = ExtImmD;
            ctrl_e_d  = CtrlD;
            valid_e_d = valid_d_q;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            pc_q         <= RESET_PC;
            instr_d_q    <= NOP_INSTR;
            pc_plus4_d_q <= '0;
            valid_d_q    <= 1'b0;
            addr_e_q     <= '0;
            rd1_e_q      <= '0;
            rd2_e_q      <= '0;
            imm_e_q      <= '0;
            ctrl_e_q     <= '0;
            valid_e_q    <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            instr_d_q    <= instr_d_d;
            pc_plus4_d_q <= pc_plus4_d_d;
            valid_d_q    <= valid_d_d;
            addr_e_q     <= addr_e_d;
            rd1_e_q      <= rd1_e_d;
            rd2_e_q      <= rd2_e_d;
            imm_e_q      <= imm_e_d;
            ctrl_e_q     <= ctrl_e_d;
            valid_e_q    <= valid_e_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst_n (RESETn),
        .inc   (StallF),
        .clr   (CntClr),
        .q     (StallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst_n (RESETn),
        .inc   (FlashD | FlashE),
        .clr   (CntClr),
        .q     (FlushCnt)
    );

    assign PCF      = pc_q;
    assign InstrD   = instr_d_q;
    assign PCPlus4D = pc_plus4_d_q;
    assign ValidD   = valid_d_q;
    assign RA1E     = addr_e_q.ra1;
    assign RA2E     = addr_e_q.ra2;
    assign WA3E     = addr_e_q.wa3;
    assign RD1E     = rd1_e_q;
    assign RD2E     = rd2_e_q;
    assign ExtImmE  = imm_e_q;
    assign CtrlE    = ctrl_e_q;
    assign ValidE   = valid_e_q;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed scoreboard bench: the driver queues hand-computed post-edge state, a monitor checks it.
module tb_fetch_decode_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 12;
    localparam int unsigned NW = 4;

    typedef struct {
        logic [31:0] pcf;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        vd;
        logic        ve;
        logic        ecap;
        logic [31:0] stall;
        logic [31:0] flush;
        logic        chk_wrap;
        int          step;
    } exp_t;

    logic          CLK;
    logic          RESETn;
    logic          StallF, StallD, FlashD, FlashE, PCSrcE, CntClr;
    logic [DW-1:0] BranchTargetE;
    logic [31:0]   InstrF;
    logic [3:0]    RA1D, RA2D, WA3D;
    logic [DW-1:0] RD1D, RD2D, ExtImmD;
    logic [CW-1:0] CtrlD;

    logic [DW-1:0] PCF, PCPlus4D, RD1E, RD2E, ExtImmE;
    logic [31:0]   InstrD;
    logic          ValidD, ValidE;
    logic [3:0]    RA1E, RA2E, WA3E;
    logic [CW-1:0] CtrlE;
    logic [NW-1:0] StallCnt, FlushCnt;

    logic [DW-1:0] w_PCF, w_PCPlus4D, w_RD1E, w_RD2E, w_ExtImmE;
    logic [31:0]   w_InstrD;
    logic          w_ValidD, w_ValidE;
    logic [3:0]    w_RA1E, w_RA2E, w_WA3E;
    logic [CW-1:0] w_CtrlE;
    logic [31:0]   w_StallCnt, w_FlushCnt;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    assign InstrF = 32'hA000_0000 | PCF;

    fetch_decode_pipe #(.CNT_W(NW)) u_dut (
        .CLK(CLK), .RESETn(RESETn),
        .StallF(StallF), .StallD(StallD), .FlashD(FlashD), .FlashE(FlashE),
        .PCSrcE(PCSrcE), .BranchTargetE(BranchTargetE), .InstrF(InstrF),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .CtrlD(CtrlD),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .CtrlE(CtrlE), .ValidE(ValidE),
        .CntClr(CntClr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    fetch_decode_pipe #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .CLK(CLK), .RESETn(RESETn),
        .StallF(StallF), .StallD(StallD), .FlashD(FlashD), .FlashE(FlashE),
        .PCSrcE(PCSrcE), .BranchTargetE(BranchTargetE), .InstrF(InstrF),
        .PCF(w_PCF), .InstrD(w_InstrD), .PCPlus4D(w_PCPlus4D), .ValidD(w_ValidD),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .CtrlD(CtrlD),
        .RA1E(w_RA1E), .RA2E(w_RA2E), .WA3E(w_WA3E),
        .RD1E(w_RD1E), .RD2E(w_RD2E), .ExtImmE(w_ExtImmE), .CtrlE(w_CtrlE), .ValidE(w_ValidE),
        .CntClr(CntClr), .StallCnt(w_StallCnt), .FlushCnt(w_FlushCnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic exp_t mk(input logic [31:0] pcf, input logic [31:0] instr,
                                input logic [31:0] pc4, input logic vd, input logic ve,
                                input logic ecap, input int stall, input int flush,
                                input logic w);
        exp_t e;
        e.pcf = pcf; e.instr = instr; e.pc4 = pc4; e.vd = vd; e.ve = ve; e.ecap = ecap;
        e.stall = 32'(stall); e.flush = 32'(flush); e.chk_wrap = w; e.step = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input int st, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s step%0d: got %h expected %h", nm, st, act, expv);
        end
    endtask

    // Apply hazard inputs, let one edge pass, then queue the state expected after it.
    task automatic cyc(input logic sf, input logic sd, input logic fd, input logic fe,
                       input logic pcs, input logic [31:0] tgt, input logic clr, input exp_t e);
        StallF = sf; StallD = sd; FlashD = fd; FlashE = fe;
        PCSrcE = pcs; BranchTargetE = tgt; CntClr = clr;
        @(posedge CLK);
        #1;
        step_no++;
        e.step = step_no;
        exp_q.push_back(e);
    endtask

    // Monitor: wakes on a falling clock or an asynchronous reset assertion.
    always begin
        @(negedge CLK or negedge RESETn);
        #1;
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("pcf",   mon_e.step, PCF, mon_e.pcf);
            chk("instrd", mon_e.step, InstrD, mon_e.instr);
            chk("pc4d",  mon_e.step, PCPlus4D, mon_e.pc4);
            chk("validd", mon_e.step, 32'(ValidD), 32'(mon_e.vd));
            chk("valide", mon_e.step, 32'(ValidE), 32'(mon_e.ve));
            chk("ctrle", mon_e.step, 32'(CtrlE), mon_e.ecap ? 32'hFFF : 32'h0);
            chk("ra1e",  mon_e.step, 32'(RA1E), mon_e.ecap ? 32'h3 : 32'h0);
            chk("wa3e",  mon_e.step, 32'(WA3E), mon_e.ecap ? 32'h7 : 32'h0);
            chk("rd1e",  mon_e.step, RD1E, mon_e.ecap ? 32'h11 : 32'h0);
            chk("immE",  mon_e.step, ExtImmE, mon_e.ecap ? 32'h33 : 32'h0);
            chk("stallcnt", mon_e.step, 32'(StallCnt), mon_e.stall);
            chk("flushcnt", mon_e.step, 32'(FlushCnt), mon_e.flush);
            if (mon_e.chk_wrap) begin
                chk("wrap_pcf", mon_e.step, w_PCF, 32'h0);
                chk("wrap_pc4d", mon_e.step, w_PCPlus4D, 32'h0);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        RESETn = 1'b0;
        StallF = 0; StallD = 0; FlashD = 0; FlashE = 0; PCSrcE = 0; CntClr = 0;
        BranchTargetE = '0;
        RA1D = 4'd3; RA2D = 4'd5; WA3D = 4'd7;
        RD1D = 32'h11; RD2D = 32'h22; ExtImmD = 32'h33; CtrlD = 12'hFFF;

        #2;
        exp_q.push_back(mk(32'h0, 32'hE1A0_0000, 32'h0, 0, 0, 0, 0, 0, 0));
        @(negedge CLK);
        RESETn = 1'b1;

        // Free-running fetch; the wrap instance rolls over on the first edge.
        cyc(0,0,0,0,0,0,0, mk(32'h4,   32'hA000_0000, 32'h4,   1,0,1, 0,0, 1));
        cyc(0,0,0,0,0,0,0, mk(32'h8,   32'hA000_0004, 32'h8,   1,1,1, 0,0, 0));
        // Load-use bubble at PCF=8.
        cyc(1,1,0,1,0,0,0, mk(32'h8,   32'hA000_0004, 32'h8,   1,0,0, 1,1, 0));
        cyc(0,0,0,0,0,0,0, mk(32'hC,   32'hA000_0008, 32'hC,   1,1,1, 1,1, 0));
        // Taken branch to 0x100 flushing D and E.
        cyc(0,0,1,1,1,32'h100,0, mk(32'h100, 32'hE1A0_0000, 32'h0, 0,0,0, 1,2, 0));
        cyc(0,0,0,0,0,0,0, mk(32'h104, 32'hA000_0100, 32'h104, 1,0,1, 1,2, 0));
        // Redirect overrides StallF; FlashD overrides StallD; StallD alone with PC advancing.
        cyc(1,0,0,0,1,32'h40,0, mk(32'h40, 32'hA000_0104, 32'h108, 1,1,1, 2,2, 0));
        cyc(0,1,1,0,0,0,0, mk(32'h44,  32'hE1A0_0000, 32'h0,   0,1,1, 2,3, 0));
        cyc(0,1,0,0,0,0,0, mk(32'h48,  32'hE1A0_0000, 32'h0,   0,0,1, 2,3, 0));
        // Clear wins over a simultaneous increment.
        cyc(1,0,0,0,0,0,1, mk(32'h48,  32'hA000_0048, 32'h4C,  1,0,1, 0,0, 0));
        // Saturation of the 4-bit stall counter.
        for (int k = 1; k <= 20; k++) begin
            cyc(1,1,0,0,0,0,0, mk(32'h48, 32'hA000_0048, 32'h4C, 1,1,1, (k > 15) ? 15 : k, 0, 0));
        end
        cyc(1,1,0,0,0,0,1, mk(32'h48,  32'hA000_0048, 32'h4C,  1,1,1, 0,0, 0));
        cyc(0,0,0,0,0,0,0, mk(32'h4C,  32'hA000_0048, 32'h4C,  1,1,1, 0,0, 0));
        cyc(0,0,0,1,0,0,0, mk(32'h50,  32'hA000_004C, 32'h50,  1,0,0, 0,1, 0));

        // Asynchronous reset between clock edges.
        StallF = 0; StallD = 0; FlashD = 0; FlashE = 0; PCSrcE = 0; CntClr = 0;
        @(negedge CLK);
        #2;
        step_no++;
        mon_e = mk(32'h0, 32'hE1A0_0000, 32'h0, 0, 0, 0, 0, 0, 0);
        mon_e.step = step_no;
        exp_q.push_back(mon_e);
        RESETn = 1'b0;
        @(negedge CLK);
        RESETn = 1'b1;
        cyc(0,0,0,0,0,0,0, mk(32'h4,   32'hA000_0000, 32'h4,   1,0,1, 0,0, 1));

        @(negedge CLK);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_decode_pipe.md
Name: fetch_decode_pipe

Overview:
- Receiving end of the hazard-control interface. Holds the PC register, the IF/ID register and the ID/EX register of the 5-stage ARM pipeline.
- Applies StallF/StallD/FlashD/FlashE and the PCSrcE redirect exactly as the hazard unit issues them.
- Supplies RA1E/RA2E/WA3E back to the hazard unit and to the forwarding muxes.
- Adds saturating stall/flush event counters for performance debug.

Parameters:
- DATA_W, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'hE1A0_0000, instruction injected into IF/ID on flush (MOV R0,R0).
- CTRL_W, 12, width of the decoded control bundle.
- CNT_W, 32, width of each event counter.

Ports:
- CLK  in  1  rising-edge clock
- RESETn  in  1  asynchronous active-low reset
- StallF  in  1  hold PC
- StallD  in  1  hold IF/ID
- FlashD  in  1  clear IF/ID to bubble
- FlashE  in  1  clear ID/EX to bubble
- PCSrcE  in  1  branch taken in Execute
- BranchTargetE  in  DATA_W  redirect address
- InstrF  in  32  instruction memory read data
- PCF  out  DATA_W  fetch address
- InstrD  out  32  decode-stage instruction
- PCPlus4D  out  DATA_W  PCF+4 captured with InstrD
- ValidD  out  1  IF/ID holds a real instruction
- RA1D, RA2D, WA3D  in  4 each  decode register addresses
- RD1D, RD2D, ExtImmD  in  DATA_W each  decode operands
- CtrlD  in  CTRL_W  decoded control bundle
- RA1E, RA2E, WA3E  out  4 each  execute register addresses
- RD1E, RD2E, ExtImmE  out  DATA_W each  execute operands
- CtrlE  out  CTRL_W  execute control bundle
- ValidE  out  1  ID/EX holds a real instruction
- CntClr  in  1  synchronous clear of both counters
- StallCnt  out  CNT_W  cycles with StallF=1
- FlushCnt  out  CNT_W  cycles with FlashD=1 or FlashE=1

Behaviour:
- Reset (async, RESETn=0): takes effect immediately, also mid-operation.
  - PCF=RESET_PC; InstrD=NOP_INSTR; PCPlus4D=0; ValidD=0.
  - All E-stage outputs=0; ValidE=0; StallCnt=FlushCnt=0.
- After reset release: first edge loads PCF=RESET_PC+4; InstrD=InstrF, ValidD=1.
- All registered outputs change only on the CLK rising edge. Each stage boundary has 1-cycle latency.
- PC register, priority order:
  - PCSrcE=1: PCF<=BranchTargetE. Overrides StallF.
  - else StallF=1: hold.
  - else: PCF<=PCF+4, wrapping modulo 2^DATA_W.
- IF/ID register, priority order:
  - FlashD=1: InstrD<=NOP_INSTR, PCPlus4D<=0, ValidD<=0. Overrides StallD.
  - else StallD=1: hold all fields.
  - else: InstrD<=InstrF, PCPlus4D<=PCF+4, ValidD<=1.
- ID/EX register:
  - FlashE=1: CtrlE[4:0]<=0, ValidE<=0; all other E fields <=0.
  - else: capture all D-side inputs; ValidE<=ValidD.
  - No stall input on this register. A load-use bubble is a FlashE, never a hold.
- CtrlE bit map (package constants):
  - bit0 RegWrite, bit1 MemWrite, bit2 MemtoReg, bit3 PCS, bit4 Branch.
  - bits CTRL_W-1:5 ALU/flag control; these carry no architectural side effect when bits 4:0 are zero.
- Flush rule: a flushed or bubbled stage never writes the register file or memory. Guaranteed by clearing bits 4:0.
- Counters:
  - StallCnt += 1 per cycle with StallF=1. FlushCnt += 1 per cycle with (FlashD|FlashE)=1.
  - Both saturate at 2^CNT_W-1.
  - CntClr=1: both go to 0 that edge. CntClr overrides a simultaneous increment.
- Illegal combination StallD=1 with StallF=0: honoured literally; PC advances, IF/ID holds. No checking logic.

Decomposition:
- Package pipe_pkg:
  - CTRL_W, bit indices CTRL_REGWRITE..CTRL_BRANCH, mask CTRL_SIDE_EFFECT=5'h1F.
  - NOP_INSTR, RESET_PC.
- Sub-module sat_counter (CNT_W param; inc, clr, q), instantiated twice. PC and stage registers are written inline.

Test Plan:
- Reset release, no hazards, InstrF=PC-tagged words -> PCF 0,4,8,C on successive edges. InstrD lags PCF by one cycle; ValidD=1 from the second edge. RESETn pulsed low mid-run -> PCF=0, ValidE=0, counters 0 with no clock edge.
- Load-use: StallF=StallD=FlashE=1 for one cycle at PCF=0x8 -> PCF holds 0x8, InstrD unchanged, CtrlE[4:0]=0, ValidE=0. StallCnt=1, FlushCnt=1.
- Branch: PCSrcE=1, BranchTargetE=0x100, FlashD=FlashE=1 -> next PCF=0x100, InstrD=E1A00000, ValidD=0, ValidE=0; following cycle PCF=0x104.
- Priority: StallF=1 with PCSrcE=1, target 0x40 -> PCF=0x40. StallD=1 with FlashD=1 -> InstrD=NOP_INSTR, ValidD=0.
- Saturation, CNT_W=4: 20 consecutive StallF cycles -> StallCnt=15. CntClr=1 in the same cycle as StallF=1 -> StallCnt=0.
- PC wrap: RESET_PC=32'hFFFF_FFFC, one free-running cycle -> PCF=0x0000_0000, PCPlus4D=0x0000_0000.
